stream_packetizer: RTL and testbench
====================================

STREAM_PACKETIZER -- requirements
Module: stream_packetizer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width.
REQ-002 The block SHALL have parameter TAG_W, default 8, meaning sideband tag width; input word width is DATA_W+TAG_W (72).
REQ-003 The block SHALL have parameter PKT_LEN, default 16, meaning payload beats per packet (range 2..65535).
REQ-004 The block SHALL have parameter SEQ_W, default 16, meaning sequence counter width.
REQ-005 The block SHALL have port clk, input, 1, meaning clock.
REQ-006 The block SHALL have port resetn, input, 1, meaning reset: synchronous, active-low.
REQ-007 The block SHALL have port ss_data, input, DATA_W+TAG_W, meaning FIFO output word: tag in [71:64], payload in [63:0].
REQ-008 The block SHALL have port ss_valid, input, 1, meaning an input word is present.
REQ-009 The block SHALL have port ss_ready, output, 1, meaning the block accepts the input word this cycle.
REQ-010 The block SHALL have port ms_data, output, DATA_W, meaning the output beat.
REQ-011 The block SHALL have port ms_valid, output, 1, meaning ms_data is valid.
REQ-012 The block SHALL have port ms_ready, input, 1, meaning downstream accepts the beat.
REQ-013 The block SHALL have port ms_last, output, 1, meaning this beat is the final beat of the packet.
REQ-014 The block SHALL have port pkt_count, output, SEQ_W, meaning packets completed, modulo 2^SEQ_W.

Function
REQ-015 A transfer SHALL occur on a side when valid && ready are both high at a rising clk edge.
REQ-016 ms_data, ms_valid and ms_last SHALL be registered; "advance" is defined as (!ms_valid || ms_ready).
REQ-017 While ms_valid && !ms_ready, ms_data and ms_last SHALL hold stable.
REQ-018 On advance with no new beat loaded, ms_valid SHALL clear.
REQ-019 The block SHALL implement states IDLE, PAY and TRL; TRL exists only under REQ-031.
REQ-020 IDLE: when ss_valid && advance, the block SHALL load the header beat without consuming the input word and go to PAY; ss_ready SHALL be 0 in IDLE.
REQ-021 The header beat SHALL be [63:56]=8'hA5, [55:48]=ss_data[71:64] (the packet tag), [47:32]=seq zero-extended/truncated to 16 bits, and [31:0]=PKT_LEN; its ms_last SHALL be 0.
REQ-022 PAY: ss_ready SHALL equal advance; each accepted word SHALL load ms_data=ss_data[63:0] on the next cycle and increment beat counter beat_cnt.
REQ-023 Tags of payload words after the first SHALL be ignored.
REQ-024 The beat with beat_cnt==PKT_LEN-1 SHALL carry ms_last=1 when the checksum is disabled, and the state SHALL then return to IDLE.
REQ-025 A packet completes when its ms_last beat transfers on the output; seq and pkt_count SHALL then increment by 1, wrapping from 2^SEQ_W-1 to 0.
REQ-026 Latency SHALL be 1 cycle from input accept to output valid; with ms_ready held high, sustained throughput SHALL be 1 beat per cycle, i.e. PKT_LEN+1 cycles per packet (PKT_LEN+2 with checksum).
REQ-027 A header load and a payload accept SHALL never occur in the same cycle.
REQ-028 An input stall mid-packet SHALL leave the state and beat_cnt unchanged; there is no timeout.

Reset
REQ-029 While resetn=0, the block SHALL drive ss_ready=0, ms_valid=0, ms_last=0, ms_data=0, pkt_count=0, seq=0, beat_cnt=0 and state=IDLE.
REQ-030 A reset asserted mid-packet SHALL discard the partial packet; after release, the next output SHALL be a fresh header with seq=0.

Configuration
REQ-031 With macro PKT_CHECKSUM_EN defined, the block SHALL keep a running XOR of payloads that is cleared at header load; the last payload beat SHALL have ms_last=0 and the state SHALL go to TRL.
REQ-032 In TRL, on advance the block SHALL load the trailer beat = XOR of all PKT_LEN payloads (including the last) with ms_last=1, with ss_ready=0, and then return to IDLE.
REQ-033 With PKT_CHECKSUM_EN undefined, the block SHALL contain no TRL state and no XOR logic, and packets SHALL be PKT_LEN+1 beats.

Structure
REQ-034 A shared package stream_pkt_pkg SHALL hold the state enum, the HDR_MAGIC=8'hA5 constant and the header field offsets.
REQ-035 Sub-module pkt_out_reg (output register with the advance/hold logic) SHALL be the only natural split; all other logic SHALL be inline.

Verification
REQ-036 Reset/idle: with PKT_LEN=4, ms_ready=1 and 4 words of tag 0x3C and payload 1..4 -> output A5_3C_0000_00000004, 1, 2, 3, 4 with ms_last on 4, then pkt_count=1.
REQ-037 Backpressure: toggling ms_ready 1010... -> every beat held stable while stalled, no beat lost or duplicated, and ss_ready=0 whenever ms_valid && !ms_ready.
REQ-038 Wrap: SEQ_W=2 with 5 packets -> header seq fields 0,1,2,3,0 and pkt_count=1 at the end.
REQ-039 Checksum (PKT_CHECKSUM_EN): payload 0xF0, 0x0F, 0xFF, 0x01 -> trailer 0x01 with ms_last=1 on the trailer only.
REQ-040 Mid-packet reset: assert resetn=0 after 2 payload beats -> outputs cleared, and the next packet header has seq=0.

Source files
------------

// File: rtl/stream_pkt_pkg.sv
// Shared definitions for the stream packetizer.
//   pkt_state_e   : packetizer FSM states (StTrl only with PKT_CHECKSUM_EN)
//   HDR_MAGIC     : constant in the top byte of every header beat
//   HDR_*_LSB     : bit offsets of the header fields
//   build_header  : assembles a 64-bit header beat from its fields
// Optional feature macro: PKT_CHECKSUM_EN.
package stream_pkt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPay  = 2'd1
`ifdef PKT_CHECKSUM_EN
        ,
        StTrl  = 2'd2
`endif
    } pkt_state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam int unsigned HDR_MAGIC_LSB = 56;
    localparam int unsigned HDR_TAG_LSB   = 48;
    localparam int unsigned HDR_SEQ_LSB   = 32;
    localparam int unsigned HDR_LEN_LSB   = 0;

    function automatic logic [63:0] build_header(input logic [7:0]  tag,
                                                 input logic [15:0] seq,
                                                 input logic [31:0] len);
        logic [63:0] hdr;
        hdr                       = '0;
        hdr[HDR_MAGIC_LSB +: 8]   = HDR_MAGIC;
        hdr[HDR_TAG_LSB   +: 8]   = tag;
        hdr[HDR_SEQ_LSB   +: 16]  = seq;
        hdr[HDR_LEN_LSB   +: 32]  = len;
        return hdr;
    endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// Registered output stage of the packetizer.
// Holds the current beat while downstream stalls and accepts a new beat
// whenever the register is empty or its beat is being taken this cycle.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   load_i      : a new beat is offered this cycle (only taken on advance)
//   data_i      : beat payload to load
//   last_i      : beat is the final beat of its packet
//   ready_i     : downstream accepts the current beat
//   advance_o   : register can take a new beat this cycle
//   valid_o, data_o, last_o : registered output beat
module pkt_out_reg #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              advance_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    always_comb begin
        advance_o = !valid_q || ready_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (advance_o) begin
            valid_q <= load_i;
            // last only meaningful alongside valid; keep it low when emptying
            last_q  <= load_i & last_i;
            if (load_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/stream_packetizer.sv
// Stream packetizer: wraps every PKT_LEN input words into a packet made of a
// header beat followed by PKT_LEN payload beats (plus an XOR trailer beat when
// PKT_CHECKSUM_EN is defined).
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   ss_data/valid/ready : input stream, tag in the top TAG_W bits
//   ms_data/valid/ready/last : registered output stream
//   pkt_count        : packets completed on the output, modulo 2^SEQ_W
// Optional feature macro: PKT_CHECKSUM_EN.
module stream_packetizer
    import stream_pkt_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned PKT_LEN = 16,
    parameter int unsigned SEQ_W   = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_W+TAG_W-1:0] ss_data,
    input  logic                    ss_valid,
    output logic                    ss_ready,
    output logic [DATA_W-1:0]       ms_data,
    output logic                    ms_valid,
    input  logic                    ms_ready,
    output logic                    ms_last,
    output logic [SEQ_W-1:0]        pkt_count
);

    localparam int unsigned BEAT_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    pkt_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;

    logic              advance;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              pkt_done;
    logic [DATA_W-1:0] payload;
    logic [7:0]        tag;
    logic [DATA_W-1:0] header;

`ifdef PKT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    assign payload = ss_data[DATA_W-1:0];
    assign tag     = 8'(ss_data[DATA_W +: TAG_W]);

    // The last beat of one packet can leave on the same edge the next header
    // loads, so the header takes the already-incremented sequence number.
    assign pkt_done = ms_valid && ms_ready && ms_last;
    assign seq_d    = pkt_done ? seq_q + SEQ_W'(1) : seq_q;
    assign header   = DATA_W'(build_header(tag, 16'(seq_d), 32'(PKT_LEN)));

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        load       = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        ss_ready   = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Header is built from the waiting word, which stays unconsumed.
                if (ss_valid && advance) begin
                    load       = 1'b1;
                    load_data  = header;
                    beat_cnt_d = '0;
`ifdef PKT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = StPay;
                end
            end
            StPay: begin
                ss_ready = advance;
                if (ss_valid && advance) begin
                    load      = 1'b1;
                    load_data = payload;
`ifdef PKT_CHECKSUM_EN
                    csum_d    = csum_q ^ payload;
`endif
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
`ifdef PKT_CHECKSUM_EN
                        state_d    = StTrl;
`else
                        load_last  = 1'b1;
                        state_d    = StIdle;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            StTrl: begin
                if (advance) begin
                    load      = 1'b1;
                    load_data = csum_q;
                    load_last = 1'b1;
                    state_d   = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
        if (!resetn) begin
            ss_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            seq_q      <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            seq_q      <= seq_d;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Sequence number and completed-packet count advance together.
    assign pkt_count = seq_q;

    pkt_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (load),
        .data_i    (load_data),
        .last_i    (load_last),
        .ready_i   (ms_ready),
        .advance_o (advance),
        .valid_o   (ms_valid),
        .data_o    (ms_data),
        .last_o    (ms_last)
    );

endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer (PKT_LEN=4, SEQ_W=2).
// Expected beats are queued as packets are issued; a negedge monitor pops and
// compares on every output transfer and checks hold-stability during stalls.
module tb_stream_packetizer;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned PKT_LEN = 4;
    localparam int unsigned SEQ_W   = 2;
`ifdef PKT_CHECKSUM_EN
    localparam int BEATS = PKT_LEN + 2;
`else
    localparam int BEATS = PKT_LEN + 1;
`endif

    logic                    clk;
    logic                    resetn;
    logic [DATA_W+TAG_W-1:0] ss_data;
    logic                    ss_valid;
    logic                    ss_ready;
    logic [DATA_W-1:0]       ms_data;
    logic                    ms_valid;
    logic                    ms_ready;
    logic                    ms_last;
    logic [SEQ_W-1:0]        pkt_count;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          bp_mode  = 0;
    int          exp_seq  = 0;
    bit          arm      = 0;
    int          t_first  = -1;
    int          t_last   = -1;
    bit          hold_v   = 0;
    logic [63:0] hold_d;
    logic        hold_l;

    stream_packetizer #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .PKT_LEN (PKT_LEN),
        .SEQ_W   (SEQ_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ss_data   (ss_data),
        .ss_valid  (ss_valid),
        .ss_ready  (ss_ready),
        .ms_data   (ms_data),
        .ms_valid  (ms_valid),
        .ms_ready  (ms_ready),
        .ms_last   (ms_last),
        .pkt_count (pkt_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Downstream ready: constant 1, or toggling 1010... in backpressure mode.
    initial begin
        ms_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) ms_ready = ~ms_ready;
            else         ms_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!resetn) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(ms_valid), 64'd1);
                check("hold_data", ms_data, hold_d);
                check("hold_last", 64'(ms_last), 64'(hold_l));
            end
            hold_v = 0;
            if (ms_valid && !ms_ready) begin
                check("stall_ss_ready", 64'(ss_ready), 64'd0);
                hold_v = 1;
                hold_d = ms_data;
                hold_l = ms_last;
            end
            if (ms_valid && ms_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h required no beat", ms_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", ms_data, e.data);
                    check("beat_last", 64'(ms_last), 64'(e.last));
                end
                if (arm) begin
                    if (t_first < 0) t_first = cyc;
                    t_last = cyc;
                end
            end
        end
    end

    task automatic push_word(input logic [71:0] w);
        bit ok;
        ok       = 0;
        ss_data  = w;
        ss_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = ss_ready;
            @(posedge clk);
            #1;
        end
        check("ss_accept", 64'(ok), 64'd1);
    endtask

    // Queue the expected beats, then drive n_words input words. Words after the
    // first carry an inverted tag which must not reach the header.
    task automatic send_packet(input logic [7:0] tag, input logic [63:0] p0,
                               input logic [63:0] p1, input logic [63:0] p2,
                               input logic [63:0] p3, input int n_words);
        logic [63:0] p[4];
        logic [63:0] x;
        beat_t       b;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        x = '0;
        b.data = {8'hA5, tag, 16'(exp_seq), 32'(PKT_LEN)};
        b.last = 1'b0;
        sb.push_back(b);
        for (int i = 0; i < n_words; i++) begin
            x      = x ^ p[i];
            b.data = p[i];
`ifdef PKT_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == 3);
`endif
            sb.push_back(b);
        end
`ifdef PKT_CHECKSUM_EN
        if (n_words == 4) begin
            b.data = x;
            b.last = 1'b1;
            sb.push_back(b);
        end
`endif
        if (n_words == 4) exp_seq = (exp_seq + 1) % 4;
        for (int i = 0; i < n_words; i++) begin
            push_word({(i == 0) ? tag : ~tag, p[i]});
        end
        ss_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        ss_valid = 1'b0;
        ss_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ss_ready", 64'(ss_ready), 64'd0);
        check("rst_ms_valid", 64'(ms_valid), 64'd0);
        check("rst_ms_last", 64'(ms_last), 64'd0);
        check("rst_ms_data", ms_data, 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        sb.delete();
        exp_seq = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn   = 1'b0;
        ss_valid = 1'b0;
        ss_data  = '0;
        do_reset();

        // Basic packet: tag 0x3C, payload 1..4.
        send_packet(8'h3C, 64'd1, 64'd2, 64'd3, 64'd4, 4);
        drain();
        check("pkt_count_1", 64'(pkt_count), 64'd1);

        // Backpressure with ready toggling.
        bp_mode = 1;
        send_packet(8'h11, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                    64'h3333_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        drain();
        bp_mode = 0;
        @(posedge clk);
        #1;
        check("pkt_count_2", 64'(pkt_count), 64'd2);

        // Three back-to-back packets: seq 2,3,0 and full throughput.
        arm     = 1;
        t_first = -1;
        fork
            begin
                send_packet(8'h21, 64'h10, 64'h20, 64'h30, 64'h40, 4);
                send_packet(8'h22, 64'h11, 64'h21, 64'h31, 64'h41, 4);
                send_packet(8'h23, 64'h12, 64'h22, 64'h32, 64'h42, 4);
            end
        join
        drain();
        arm = 0;
        check("throughput", 64'(t_last - t_first), 64'(3 * BEATS - 1));
        check("pkt_count_wrap", 64'(pkt_count), 64'd1);

        // Checksum pattern: trailer 0x01 when enabled.
        send_packet(8'h5A, 64'hF0, 64'h0F, 64'hFF, 64'h01, 4);
        drain();
        check("pkt_count_csum", 64'(pkt_count), 64'd2);

        // Mid-packet reset after two payload beats.
        send_packet(8'h77, 64'hAA, 64'hBB, 64'hCC, 64'hDD, 2);
        drain();
        do_reset();
        send_packet(8'h44, 64'h5, 64'h6, 64'h7, 64'h8, 4);
        drain();
        check("pkt_count_post_rst", 64'(pkt_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
